tpu_fp8_encoder: RTL and testbench
==================================

TPU_FP8_ENCODER -- requirements
Module: tpu_fp8_encoder

Interface
REQ-001 SHALL have parameter SCALE_SHIFT, default 0, meaning the accumulator is arithmetically right-shifted by SCALE_SHIFT (legal range 0..16) before encoding.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request one readback/encode of the MAC accumulator.
REQ-005 SHALL have port acc_half, input, 17 bits: selected MAC accumulator half; bits [16:0] when out_hl=0, bits [33:17] when out_hl=1.
REQ-006 SHALL have port mac_error, input, 1 bit: MAC shifter overflow flag.
REQ-007 SHALL have port out_hl, output, 1 bit: half select driven to the MAC.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port fp8_out, output, 8 bits: result in sign[7], exponent[6:3], mantissa[2:0] format.
REQ-010 SHALL have port fp8_valid, output, 1 bit: fp8_out, sat and err hold a result.
REQ-011 SHALL have port fp8_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port sat, output, 1 bit: result clipped to the largest magnitude.
REQ-013 SHALL have port err, output, 1 bit: mac_error was high during either capture cycle.

Function
REQ-014 SHALL implement the FSM IDLE -> RD_LO -> RD_HI -> CONV -> HOLD -> IDLE.
REQ-015 SHALL move IDLE->RD_LO on the edge sampling start=1; start in any other state is ignored, with no queueing.
REQ-016 SHALL drive out_hl=0 in RD_LO, capture acc_half into acc[16:0] and move to RD_HI at the end of the cycle.
REQ-017 SHALL drive out_hl=1 in RD_HI, capture acc_half into acc[33:17] and move to CONV.
REQ-018 SHALL drive out_hl=0 in IDLE, CONV and HOLD.
REQ-019 SHALL, in CONV, treat acc as 34-bit two's complement, form sign and a 34-bit unsigned magnitude (-2^33 is legal), and right-shift the magnitude by SCALE_SHIFT with round-half-up (add the highest discarded bit).
REQ-020 SHALL encode the magnitude V after the shift: V<8 gives exp=0, mant=V; otherwise, with p the leading-one position (p>=3), exp=p-2 and mant=V[p-1:p-3], rounded half-up on V[p-4].
REQ-021 SHALL propagate a mantissa carry from rounding into exp+1 with mant=0.
REQ-022 SHALL saturate when the final exp would exceed 15: magnitude field 0x7F and sat=1.
REQ-023 SHALL encode zero magnitude as 0x00, never as negative zero.
REQ-024 SHALL register fp8_out, sat and err at the end of CONV, so fp8_valid rises exactly 4 cycles after the edge that sampled start.
REQ-025 SHALL hold fp8_valid and all results stable in HOLD until fp8_ready=1, then return to IDLE on that edge.
REQ-026 SHALL accept fp8_ready=1 in the first HOLD cycle, giving back-to-back throughput of one result per 5 cycles.
REQ-027 SHALL capture both halves without checking stability; the integrator keeps the MAC accumulator frozen from RD_LO through RD_HI.

Reset
REQ-028 SHALL, on reset=0, immediately force state IDLE, acc=0, fp8_out=0x00, fp8_valid=0, sat=0, err=0, out_hl=0 and busy=0, in any state including mid-readback.
REQ-029 SHALL emit no partial result after reset release; a new start is required.

Structure
REQ-030 SHALL take ACC_W=34, HALF_W=17, FP8 field widths/positions, EXP_MAX=15 and the FSM state enum from shared package tpu_pkg.
REQ-031 SHALL place leading-one detect, normalize and round (combinational, 34-bit in, exp/mant/sat out) in one sub-module, fp8_normalize.

Verification
REQ-032 SHALL cover: accumulator +5 with SCALE_SHIFT=0 -> fp8_out 0x05, sat=0, fp8_valid 4 cycles after start, out_hl sequence 0,1.
REQ-033 SHALL cover: +19 -> 0x12 (9.5 rounds to 10); +31 -> 0x18 (carry into exponent); -8 (0x3_FFFF_FFF8) -> 0x88.
REQ-034 SHALL cover: +245760 -> 0x7F, sat=0; +300000 -> 0x7F, sat=1; -2^33 -> 0xFF, sat=1.
REQ-035 SHALL cover: fp8_ready held 0 for 10 cycles -> fp8_valid and fp8_out stable, and a second start during HOLD is ignored.
REQ-036 SHALL cover: reset=0 asserted during RD_HI -> all outputs 0 immediately, no fp8_valid after release until a new start.
REQ-037 SHALL cover: mac_error=1 only in RD_LO -> err=1 with the result, err=0 on the next clean readback.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants, FP8 field layout and FSM state encoding for the TPU FP8
// accumulator encoder.
package tpu_pkg;

  localparam int ACC_W    = 34;
  localparam int HALF_W   = 17;
  localparam int FP8_W    = 8;
  localparam int EXP_W    = 4;
  localparam int MANT_W   = 3;
  localparam int SIGN_POS = 7;
  localparam int EXP_LSB  = 3;
  localparam int MANT_LSB = 0;
  localparam int EXP_MAX  = 15;
  // Wide enough for a leading-one index of 0..33 plus the carry exponent.
  localparam int LEAD_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_CONV  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  function automatic logic [FP8_W-1:0] fp8_pack(input logic sign,
                                                input logic [EXP_W-1:0] exp_field,
                                                input logic [MANT_W-1:0] mant_field);
    logic [FP8_W-1:0] word;
    word = '0;
    word[SIGN_POS] = sign;
    word[EXP_LSB +: EXP_W] = exp_field;
    word[MANT_LSB +: MANT_W] = mant_field;
    return word;
  endfunction

endpackage

// File: rtl/tpu_fp8_encoder_if.sv
// Signal bundle between the MAC / result consumer (master) and the FP8
// encoder (slave).
interface tpu_fp8_encoder_if;
  import tpu_pkg::*;

  logic              start;
  logic [HALF_W-1:0] acc_half;
  logic              mac_error;
  logic              out_hl;
  logic              busy;
  logic [FP8_W-1:0]  fp8_out;
  logic              fp8_valid;
  logic              fp8_ready;
  logic              sat;
  logic              err;

  // Result handshake: a result transfers on a rising clk edge where
  // fp8_valid && fp8_ready; once fp8_valid is high it stays high, and
  // fp8_out/sat/err stay unchanged, until that edge. fp8_ready may be high
  // at any time and has no effect while fp8_valid is low.
  modport master (
    output start, acc_half, mac_error, fp8_ready,
    input  out_hl, busy, fp8_out, fp8_valid, sat, err
  );

  modport slave (
    input  start, acc_half, mac_error, fp8_ready,
    output out_hl, busy, fp8_out, fp8_valid, sat, err
  );

endinterface

// File: rtl/fp8_normalize.sv
// Leading-one detect, normalize and round-half-up of an unsigned magnitude
// into a 4-bit exponent / 3-bit mantissa, with saturation.
module fp8_normalize
  import tpu_pkg::*;
(
  input  logic [ACC_W-1:0]  mag,
  output logic [EXP_W-1:0]  exp_field,
  output logic [MANT_W-1:0] mant_field,
  output logic              sat
);

  logic [LEAD_W-1:0] lead;
  logic [3:0]        win;
  logic [MANT_W:0]   mant_sum;
  logic [LEAD_W-1:0] exp_full;

  always_comb begin
    lead = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) lead = LEAD_W'(i);
    end

    win      = '0;
    mant_sum = '0;
    exp_full = '0;
    if (mag < ACC_W'(8)) begin
      mant_sum = {1'b0, mag[2:0]};
    end else begin
      // win = {V[p-1:p-3], V[p-4]}; the appended zero supplies the round bit at p=3.
      win      = 4'({mag, 1'b0} >> (lead - LEAD_W'(3)));
      mant_sum = {1'b0, win[3:1]} + {3'b000, win[0]};
      // A mantissa carry leaves mant_sum[2:0]=0 and bumps the exponent.
      exp_full = lead - LEAD_W'(2) + {{(LEAD_W-1){1'b0}}, mant_sum[MANT_W]};
    end

    sat        = (exp_full > LEAD_W'(EXP_MAX));
    exp_field  = sat ? EXP_W'(EXP_MAX) : exp_full[EXP_W-1:0];
    mant_field = sat ? '1 : mant_sum[MANT_W-1:0];
  end

endmodule

// File: rtl/tpu_fp8_encoder.sv
// Reads a 34-bit MAC accumulator in two 17-bit halves, scales it and encodes
// it as sign/exp/mant FP8, holding the result until the consumer accepts it.
module tpu_fp8_encoder
  import tpu_pkg::*;
#(
  parameter int SCALE_SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset,
  tpu_fp8_encoder_if.slave   bus,
  output state_e             state_dbg
);

  state_e state, state_nx;

  logic [ACC_W-1:0] acc;
  logic             err_acc;
  logic [FP8_W-1:0] fp8_q;
  logic             valid_q;
  logic             sat_q;
  logic             err_q;

  logic              sign;
  logic [ACC_W-1:0]  mag;
  logic [ACC_W:0]    mag_ext;
  logic [ACC_W-1:0]  mag_s;
  logic [EXP_W-1:0]  exp_field;
  logic [MANT_W-1:0] mant_field;
  logic              norm_sat;
  logic [FP8_W-1:0]  fp8_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_RD_LO;
      ST_RD_LO: state_nx = ST_RD_HI;
      ST_RD_HI: state_nx = ST_CONV;
      ST_CONV:  state_nx = ST_HOLD;
      ST_HOLD:  if (bus.fp8_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Two's complement magnitude; -2^33 maps to 2^33, which still fits 34 bits.
  assign sign    = acc[ACC_W-1];
  assign mag     = sign ? -acc : acc;
  assign mag_ext = {mag, 1'b0} >> SCALE_SHIFT;
  assign mag_s   = mag_ext[ACC_W:1] + {{(ACC_W-1){1'b0}}, mag_ext[0]};

  fp8_normalize u_normalize (
    .mag        (mag_s),
    .exp_field  (exp_field),
    .mant_field (mant_field),
    .sat        (norm_sat)
  );

  // A magnitude that scales down to zero is reported as +0.
  assign fp8_nx = fp8_pack(sign & (mag_s != '0), exp_field, mant_field);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      err_acc <= 1'b0;
      fp8_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_RD_LO: begin
          acc[HALF_W-1:0] <= bus.acc_half;
          err_acc         <= bus.mac_error;
        end
        ST_RD_HI: begin
          acc[ACC_W-1:HALF_W] <= bus.acc_half;
          err_acc             <= err_acc | bus.mac_error;
        end
        ST_CONV: begin
          fp8_q   <= fp8_nx;
          sat_q   <= norm_sat;
          err_q   <= err_acc;
          valid_q <= 1'b1;
        end
        ST_HOLD: if (bus.fp8_ready) valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.out_hl    = (state == ST_RD_HI);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.fp8_out   = fp8_q;
  assign bus.fp8_valid = valid_q;
  assign bus.sat       = sat_q;
  assign bus.err       = err_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_tpu_fp8_encoder.sv
// Directed bench for tpu_fp8_encoder: one DUT unscaled, one with SCALE_SHIFT=4,
// both fed the same MAC accumulator and handshake.
module tb_tpu_fp8_encoder;
  import tpu_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [ACC_W-1:0] mac_acc;
  state_e           state0, state4;

  int n_vec  = 0;
  int n_miss = 0;
  // Expected {err,sat,fp8} for the unscaled DUT in [19:10], scaled DUT in [9:0].
  logic [19:0] exp_q[$];

  tpu_fp8_encoder_if bus();
  tpu_fp8_encoder_if bus4();

  // clock / reset block
  always #5 clk = ~clk;

  // MAC model: returns the half selected by out_hl.
  assign bus.acc_half   = bus.out_hl  ? mac_acc[33:17] : mac_acc[16:0];
  assign bus4.acc_half  = bus4.out_hl ? mac_acc[33:17] : mac_acc[16:0];
  assign bus4.start     = bus.start;
  assign bus4.mac_error = bus.mac_error;
  assign bus4.fp8_ready = bus.fp8_ready;

  tpu_fp8_encoder #(.SCALE_SHIFT(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state0)
  );

  tpu_fp8_encoder #(.SCALE_SHIFT(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus4),
    .state_dbg (state4)
  );

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one full readback/encode, optionally stalling fp8_ready in HOLD
  task automatic encode(input string tag, input logic [33:0] a, input logic e_lo,
                        input logic e_hi, input int stall, input logic [19:0] expv);
    logic [19:0] e;
    logic [7:0]  held;
    mac_acc = a;
    exp_q.push_back(expv);
    check({tag, ".idle"}, 34'({state0, bus.busy}), 34'({ST_IDLE, 1'b0}));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.mac_error = e_lo;
    check({tag, ".rd_lo"}, 34'({state0, bus.out_hl, bus.busy, bus.fp8_valid}),
          34'({ST_RD_LO, 3'b010}));
    step();
    bus.mac_error = e_hi;
    check({tag, ".rd_hi"}, 34'({state0, bus.out_hl, bus.busy, bus.fp8_valid}),
          34'({ST_RD_HI, 3'b110}));
    step();
    bus.mac_error = 1'b0;
    check({tag, ".conv"}, 34'({state0, bus.out_hl, bus.busy, bus.fp8_valid}),
          34'({ST_CONV, 3'b010}));
    step();
    check({tag, ".hold"}, 34'({state0, bus.out_hl, bus.busy, bus.fp8_valid, bus4.fp8_valid}),
          34'({ST_HOLD, 4'b0111}));
    e = exp_q.pop_front();
    check({tag, ".res0"}, 34'({bus.err, bus.sat, bus.fp8_out}), 34'(e[19:10]));
    check({tag, ".res4"}, 34'({bus4.err, bus4.sat, bus4.fp8_out}), 34'(e[9:0]));
    held = bus.fp8_out;
    for (int k = 0; k < stall; k++) begin
      bus.start = (k == 2);
      step();
      check({tag, ".stall"}, 34'({state0, bus.fp8_valid, bus.fp8_out}),
            34'({ST_HOLD, 1'b1, held}));
    end
    bus.start = 1'b0;
    bus.fp8_ready = 1'b1;
    step();
    bus.fp8_ready = 1'b0;
    check({tag, ".done"}, 34'({state0, bus.busy, bus.fp8_valid}), 34'({ST_IDLE, 2'b00}));
    if (stall > 0) begin
      step();
      check({tag, ".noqueue"}, 34'({state0, state4, bus.busy}), 34'({ST_IDLE, ST_IDLE, 1'b0}));
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.mac_error = 1'b0;
    bus.fp8_ready = 1'b0;
    mac_acc = '0;
    repeat (3) step();
    check("reset_state", 34'({state0, bus.out_hl, bus.busy, bus.fp8_valid, bus.sat, bus.err, bus.fp8_out}),
          34'({ST_IDLE, 5'b00000, 8'h00}));
    reset = 1'b1;
    step();

    // back-to-back encodes, each result accepted in its first HOLD cycle
    encode("pos5",    34'd5,            1'b0, 1'b0, 0, {10'h005, 10'h000});
    encode("pos19",   34'd19,           1'b0, 1'b0, 0, {10'h012, 10'h001});
    encode("pos31",   34'd31,           1'b0, 1'b0, 0, {10'h018, 10'h002});
    encode("neg8",    34'h3_FFFF_FFF8,  1'b0, 1'b0, 0, {10'h088, 10'h081});
    encode("max",     34'd245760,       1'b0, 1'b0, 0, {10'h07F, 10'h05F});
    encode("over",    34'd300000,       1'b0, 1'b0, 0, {10'h17F, 10'h061});
    encode("negmin",  34'h2_0000_0000,  1'b0, 1'b0, 0, {10'h1FF, 10'h1FF});
    encode("zero",    34'd0,            1'b0, 1'b0, 0, {10'h000, 10'h000});

    // consumer stall with an ignored start during HOLD
    encode("stall19", 34'd19,           1'b0, 1'b0, 10, {10'h012, 10'h001});

    // MAC error flag in either capture cycle
    encode("err_lo",  34'd5,            1'b1, 1'b0, 0, {10'h205, 10'h200});
    encode("clean",   34'd5,            1'b0, 1'b0, 0, {10'h005, 10'h000});
    encode("err_hi",  34'd19,           1'b0, 1'b1, 0, {10'h212, 10'h201});

    // reset asserted mid-readback clears everything at once
    mac_acc = 34'd300000;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("pre_reset.rd_hi", 34'({state0, bus.out_hl}), 34'({ST_RD_HI, 1'b1}));
    reset = 1'b0;
    #1;
    check("async_reset", 34'({state0, bus.out_hl, bus.busy, bus.fp8_valid, bus.sat, bus.err, bus.fp8_out}),
          34'({ST_IDLE, 5'b00000, 8'h00}));
    check("async_reset4", 34'({state4, bus4.fp8_valid, bus4.err, bus4.fp8_out}),
          34'({ST_IDLE, 2'b00, 8'h00}));
    step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_reset_quiet", 34'({bus.busy, bus.fp8_valid, bus4.fp8_valid}), 34'(3'b000));
    end

    encode("after_reset", 34'd31, 1'b0, 1'b0, 0, {10'h018, 10'h002});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
